// File: rtl/four_bit_ripple_counter.sv
// Free-running WIDTH-bit up-counter with async active-low clear and terminal-count decode.
// Define FOUR_BIT_RIPPLE_COUNTER_RIPPLE_EN for a toggle-flop ripple chain; default is a synchronous register.
module four_bit_ripple_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             RSTn,
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  logic [WIDTH-1:0] r_q;

`ifdef FOUR_BIT_RIPPLE_COUNTER_RIPPLE_EN
  logic [WIDTH-1:0] w_stage_clk;

  // Stage i advances when stage i-1 falls 1->0, i.e. on the rising edge of its inverted Q.
  assign w_stage_clk[0] = clk;
  for (genvar gi = 1; gi < WIDTH; gi++) begin : g_stage_clk
    assign w_stage_clk[gi] = ~r_q[gi-1];
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tff
    always_ff @(posedge w_stage_clk[gi] or negedge RSTn) begin
      if (!RSTn) begin
        r_q[gi] <= 1'b0;
      end else begin
        r_q[gi] <= ~r_q[gi];
      end
    end
  end
`else
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_q <= '0;
    end else begin
      r_q <= r_q + 1'b1;
    end
  end
`endif

  assign out = r_q;
  assign tc  = &r_q;

endmodule

// File: tb/tb_four_bit_ripple_counter.sv
// Directed self-checking bench for four_bit_ripple_counter: reset hold, counting, wrap/tc,
// async clear mid-count, coincident reset release and a long run against a reference count.
`timescale 1ns/1ps
module tb_four_bit_ripple_counter;

  logic       clk;
  logic       RSTn;
  logic [3:0] out;
  logic       tc;

  int unsigned n_cmp;
  int unsigned n_bad;

  four_bit_ripple_counter #(.WIDTH(4)) dut (
    .clk  (clk),
    .RSTn (RSTn),
    .out  (out),
    .tc   (tc)
  );

  initial clk = 1'b0;
  always #1 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, need $finish)");
    $fatal(1);
  end

  // Advance n rising edges, then settle at the following falling edge for sampling.
  task automatic edges(input int unsigned n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Clear and release away from any rising edge; count sits at 0 afterwards.
  task automatic do_reset();
    @(negedge clk);
    RSTn = 1'b0;
    @(negedge clk);
    RSTn = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    RSTn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #0.5;
      n_cmp++;
      if (out !== 4'h0) begin
        n_bad++;
        $display("FAIL reset_hold_out[%0d]: got %h need 0", i, out);
      end
      n_cmp++;
      if (tc !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_hold_tc[%0d]: got %b need 0", i, tc);
      end
    end
  endtask

  task automatic test_count();
    logic [3:0] exp_tab [20];
    // Hand-computed (5*k) mod 16 for k = 1..20.
    exp_tab = '{4'h5, 4'hA, 4'hF, 4'h4, 4'h9, 4'hE, 4'h3, 4'h8, 4'hD, 4'h2,
                4'h7, 4'hC, 4'h1, 4'h6, 4'hB, 4'h0, 4'h5, 4'hA, 4'hF, 4'h4};
    do_reset();
    for (int k = 0; k < 20; k++) begin
      edges(5);
      n_cmp++;
      if (out !== exp_tab[k]) begin
        n_bad++;
        $display("FAIL count_edge%0d: got %h need %h", 5*(k+1), out, exp_tab[k]);
      end
    end
  endtask

  task automatic test_wrap_tc();
    do_reset();
    edges(14);
    n_cmp++;
    if (tc !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_tc_at_E: got %b need 0", tc);
    end
    edges(1);
    n_cmp++;
    if (out !== 4'hF) begin
      n_bad++;
      $display("FAIL wrap_out_15: got %h need f", out);
    end
    n_cmp++;
    if (tc !== 1'b1) begin
      n_bad++;
      $display("FAIL wrap_tc_15: got %b need 1", tc);
    end
    edges(1);
    n_cmp++;
    if (out !== 4'h0) begin
      n_bad++;
      $display("FAIL wrap_out_16: got %h need 0", out);
    end
    n_cmp++;
    if (tc !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_tc_16: got %b need 0", tc);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    edges(11);
    n_cmp++;
    if (out !== 4'hB) begin
      n_bad++;
      $display("FAIL async_pre_B: got %h need b", out);
    end
    #0.3;
    RSTn = 1'b0;
    #0.1;
    n_cmp++;
    if (out !== 4'h0) begin
      n_bad++;
      $display("FAIL async_clear: got %h need 0", out);
    end
    @(negedge clk);
    RSTn = 1'b1;
    edges(1);
    n_cmp++;
    if (out !== 4'h1) begin
      n_bad++;
      $display("FAIL async_first_inc: got %h need 1", out);
    end
  endtask

  task automatic test_coincident_release();
    do_reset();
    edges(6);
    @(negedge clk);
    RSTn = 1'b0;
    @(posedge clk);
    // Release lands in the same timestep as the rising edge but after the flops sample it.
    RSTn <= 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out !== 4'h0) begin
      n_bad++;
      $display("FAIL coincident_hold: got %h need 0", out);
    end
    edges(1);
    n_cmp++;
    if (out !== 4'h1) begin
      n_bad++;
      $display("FAIL coincident_next: got %h need 1", out);
    end
  endtask

  task automatic test_long_run();
    int unsigned exp_cnt;
    do_reset();
    exp_cnt = 0;
    for (int k = 0; k < 200; k++) begin
      edges(5);
      exp_cnt = (exp_cnt + 5) % 16;
      n_cmp++;
      if (out !== 4'(exp_cnt) || tc !== (exp_cnt == 15)) begin
        n_bad++;
        $display("FAIL long_run[%0d]: got out=%h tc=%b need out=%h tc=%b",
                 k, out, tc, 4'(exp_cnt), (exp_cnt == 15));
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RSTn  = 1'b0;
    test_reset();
    test_count();
    test_wrap_tc();
    test_async_reset();
    test_coincident_release();
    test_long_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
